// File: rtl/zombie_spawner.sv
// Whack-a-zombie round controller: raises a pseudo-random zombie, judges button presses as hit or miss.
// Optional ZOMBIE_EARLY_PENALTY_EN: presses during the dark gap count as misses and restart the gap.
module zombie_spawner #(
   parameter logic [7:0]  LFSR_SEED = 8'hA5,
   parameter int unsigned WINDOW    = 16,
   parameter int unsigned GAP       = 4,
   parameter int unsigned ROUNDS    = 30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:1] btn,
   output logic [2:0] zombie_led,
   output logic [7:0] score,
   output logic [7:0] misses,
   output logic       hit,
   output logic       miss,
   output logic       busy,
   output logic       done
);

   localparam int unsigned WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [7:0]  SEED  = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

   typedef enum logic [1:0] {S_IDLE, S_GAP, S_UP, S_DONE} state_t;

   state_t           state;
   logic [2:0]       btn_q;
   logic [7:0]       lfsr;
   logic [7:0]       round_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic [WIN_W-1:0] win_cnt;

   logic [2:0] press_c;
   logic       any_c;
   logic       single_c;
   logic       match_c;
   logic       fb_c;

   // Hole selection; the top code folds onto holes 3 or 1 to keep all three reachable.
   function automatic logic [2:0] pick_hole(input logic [7:0] l);
      logic [2:0] h;
      case (l[1:0])
         2'd0:    h = 3'b001;
         2'd1:    h = 3'b010;
         2'd2:    h = 3'b100;
         default: h = l[2] ? 3'b100 : 3'b001;
      endcase
      return h;
   endfunction

   always_comb begin
      press_c  = btn & ~btn_q;
      any_c    = |press_c;
      single_c = (press_c == 3'b001) || (press_c == 3'b010) || (press_c == 3'b100);
      match_c  = single_c && (press_c == zombie_led);
      fb_c     = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= S_IDLE;
         btn_q      <= 3'b000;
         lfsr       <= SEED;
         round_cnt  <= 8'd0;
         gap_cnt    <= '0;
         win_cnt    <= '0;
         zombie_led <= 3'b000;
         score      <= 8'd0;
         misses     <= 8'd0;
         hit        <= 1'b0;
         miss       <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         btn_q <= btn;
         lfsr  <= {lfsr[6:0], fb_c};
         hit   <= 1'b0;
         miss  <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state     <= S_GAP;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  score     <= 8'd0;
                  misses    <= 8'd0;
                  round_cnt <= 8'd0;
                  gap_cnt   <= '0;
               end
            end
            S_GAP: begin
`ifdef ZOMBIE_EARLY_PENALTY_EN
               if (any_c) begin
                  miss    <= 1'b1;
                  gap_cnt <= '0;
                  if (misses != 8'hFF) misses <= misses + 8'd1;
               end else
`endif
               if (gap_cnt == GAP_W'(GAP - 1)) begin
                  state      <= S_UP;
                  zombie_led <= pick_hole(lfsr);
                  win_cnt    <= '0;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end
            S_UP: begin
               // A press in the last window cycle is judged by the press, not as a timeout.
               if (any_c || (win_cnt == WIN_W'(WINDOW - 1))) begin
                  if (match_c) begin
                     hit <= 1'b1;
                     if (score != 8'hFF) score <= score + 8'd1;
                  end else begin
                     miss <= 1'b1;
                     if (misses != 8'hFF) misses <= misses + 8'd1;
                  end
                  zombie_led <= 3'b000;
                  round_cnt  <= round_cnt + 8'd1;
                  gap_cnt    <= '0;
                  if (round_cnt + 8'd1 == 8'(ROUNDS)) begin
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= S_GAP;
                  end
               end else begin
                  win_cnt <= win_cnt + WIN_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
